uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: latches a byte on accept and steps the TX mux through
// start, data (LSB first), optional parity and stop, one bit per clock.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

  localparam logic [1:0] SelStart  = 2'b00;
  localparam logic [1:0] SelData   = 2'b01;
  localparam logic [1:0] SelParity = 2'b10;
  localparam logic [1:0] SelStop   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [1:0]              mux_sel_q, mux_sel_d;
  logic                    ser_data_q, ser_data_d;
  logic                    par_bit_q, par_bit_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;

    unique case (state_q)
      StIdle: begin
        if (data_valid) begin
          data_d    = p_data;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          cnt_d     = '0;
          state_d   = StStart;
        end
      end
      StStart: state_d = StData;
      StData: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = par_en_q ? StParity : StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: state_d = StStop;
      StStop:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next-state values so the output flops always agree with
  // the state flops in the same cycle, with no input-to-output combinational path.
  always_comb begin
    mux_sel_d = SelStop;
    unique case (state_d)
      StIdle:   mux_sel_d = SelStop;
      StStart:  mux_sel_d = SelStart;
      StData:   mux_sel_d = SelData;
      StParity: mux_sel_d = SelParity;
      StStop:   mux_sel_d = SelStop;
      default:  mux_sel_d = SelStop;
    endcase
    busy_d     = (state_d != StIdle);
    ser_data_d = data_d[cnt_d];
    par_bit_d  = (^data_d) ^ par_typ_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      mux_sel_q  <= SelStop;
      ser_data_q <= 1'b0;
      par_bit_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      mux_sel_q  <= mux_sel_d;
      ser_data_q <= ser_data_d;
      par_bit_q  <= par_bit_d;
      busy_q     <= busy_d;
    end
  end

  assign mux_sel  = mux_sel_q;
  assign ser_data = ser_data_q;
  assign par_bit  = par_bit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-list reference model predicts every output cycle, plus
// directed checks on frame length, bit order, gaps and ignored mid-frame requests.
module tb_uart_tx_ctrl;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] p_data = '0;
  logic          data_valid = 1'b0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [1:0]    mux_sel;
  logic          ser_data;
  logic          par_bit;
  logic          busy;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model: one entry per expected output cycle of the frame in flight.
  typedef struct packed {
    logic [1:0] mux;
    logic       busy;
    logic       ser;
    logic       par;
  } exp_t;

  logic [DW-1:0] m_data = '0;
  logic          m_pe   = 1'b0;
  logic          m_pt   = 1'b0;
  logic          m_idle = 1'b1;
  exp_t          m_cur  = 5'b11000;
  exp_t          m_q[$];

  function automatic exp_t frame_bit(input logic [1:0] mux, input logic b, input logic ser);
    exp_t e;
    e.mux  = mux;
    e.busy = b;
    e.ser  = ser;
    e.par  = (^m_data) ^ m_pt;
    return e;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_data = '0;
      m_pe   = 1'b0;
      m_pt   = 1'b0;
      m_q.delete();
      m_idle = 1'b1;
      m_cur  = 5'b11000;
    end else begin
      if (m_idle && data_valid) begin
        m_data = p_data;
        m_pe   = par_en;
        m_pt   = par_typ;
        m_q.push_back(frame_bit(2'b00, 1'b1, m_data[0]));
        for (int i = 0; i < DW; i++) m_q.push_back(frame_bit(2'b01, 1'b1, m_data[i]));
        if (m_pe) m_q.push_back(frame_bit(2'b10, 1'b1, m_data[0]));
        m_q.push_back(frame_bit(2'b11, 1'b1, m_data[0]));
      end
      if (m_q.size() > 0) begin
        m_cur  = m_q.pop_front();
        m_idle = 1'b0;
      end else begin
        m_cur  = frame_bit(2'b11, 1'b0, m_data[0]);
        m_idle = 1'b1;
      end
    end
  endtask

  // Observed frame statistics, compared against fixed expectations in directed tests.
  int            busy_run = 0, last_busy_len = 0, idle_run = 0, gap_before_start = 0;
  int            last_start_cyc = 0, period = 0, n_starts = 0;
  logic          saw_par_code = 1'b0;
  logic [DW-1:0] cap = '0, last_cap = '0, prev_cap = '0;
  logic [1:0]    prev_mux = 2'b11;

  task automatic observe();
    if (busy) busy_run++;
    else begin
      if (busy_run > 0) last_busy_len = busy_run;
      busy_run = 0;
    end
    if (mux_sel == 2'b10) saw_par_code = 1'b1;
    if (mux_sel == 2'b00) begin
      n_starts++;
      period           = cyc - last_start_cyc;
      last_start_cyc   = cyc;
      gap_before_start = idle_run;
    end
    if (!busy) idle_run++;
    else idle_run = 0;
    if (mux_sel == 2'b01) cap = {ser_data, cap[DW-1:1]};
    else if (prev_mux == 2'b01) begin
      prev_cap = last_cap;
      last_cap = cap;
    end
    prev_mux = mux_sel;
  endtask

  task automatic cycle(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic pe, input logic pt);
    @(negedge clk);
    rst        = r;
    data_valid = v;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_eq("frame_out", {27'd0, mux_sel, busy, ser_data, par_bit}, {27'd0, m_cur});
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  int s0;

  initial begin
    // Reset with live-looking inputs, including a request.
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'b1, DW'($urandom), 1'($urandom), 1'($urandom));
    check_eq("rst_mux", {30'd0, mux_sel}, 32'd3);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    idle(2);
    check_eq("rst_release_busy", {31'd0, busy}, 32'd0);

    // Even parity 0xA5.
    cycle(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    check_eq("even_par_bit", {31'd0, par_bit}, 32'd0);
    idle(12);
    check_eq("even_busy_len", last_busy_len, 32'd11);
    check_eq("even_bits", {24'd0, last_cap}, 32'hA5);

    // Odd parity 0xA5.
    cycle(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
    check_eq("odd_par_bit", {31'd0, par_bit}, 32'd1);
    idle(12);
    check_eq("odd_busy_len", last_busy_len, 32'd11);

    // No parity 0x00.
    saw_par_code = 1'b0;
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    idle(12);
    check_eq("nopar_busy_len", last_busy_len, 32'd10);
    check_eq("nopar_no_10", {31'd0, saw_par_code}, 32'd0);
    check_eq("nopar_bits", {24'd0, last_cap}, 32'h00);

    // Requests and input changes during DATA are ignored.
    s0 = n_starts;
    cycle(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
    idle(12);
    check_eq("mid_bits", {24'd0, last_cap}, 32'hA5);
    check_eq("mid_one_frame", n_starts - s0, 32'd1);
    check_eq("mid_busy_len", last_busy_len, 32'd11);

    // Reset during DATA bit 3, then a clean 0x3C frame.
    cycle(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    idle(4);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("rstmid_mux", {30'd0, mux_sel}, 32'd3);
    check_eq("rstmid_busy", {31'd0, busy}, 32'd0);
    idle(1);
    cycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    idle(12);
    check_eq("rstmid_next_bits", {24'd0, last_cap}, 32'h3C);
    check_eq("rstmid_next_len", last_busy_len, 32'd11);

    // Back-to-back frames with data_valid held high.
    cycle(1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    idle(14);
    check_eq("b2b_period", period, 32'd12);
    check_eq("b2b_gap", gap_before_start, 32'd1);
    check_eq("b2b_first_bits", {24'd0, prev_cap}, 32'h01);
    check_eq("b2b_second_bits", {24'd0, last_cap}, 32'h80);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0),
            DW'($urandom), 1'($urandom), 1'($urandom));
    idle(14);
    check_eq("final_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
